// File: rtl/tinyalu_pkg.sv
// Shared types and defaults for the processor memory port.
// Used by the responder FSM and its backing array.
package tinyalu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } mem_state_t;

   typedef enum logic {
      MEM_RD,
      MEM_WR
   } mem_op_t;

   localparam int MEM_ADDR_W = 14;
   localparam int MEM_DATA_W = 16;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, registered read port.
// Read register holds its value until the next read.
import tinyalu_pkg::*;

module mem_array #(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];
   logic [DATA_W-1:0] r_rdata;

   // Contents survive reset; only the output register clears.
   always_ff @(posedge i_clk) begin
      if (i_we)
         r_mem[i_addr] <= i_wdata;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_rdata <= '0;
      else if (i_re)
         r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latched request, programmable latency,
// four-phase response handshake in front of mem_array.
import tinyalu_pkg::*;

module mem_responder #(
   parameter int ADDR_W    = MEM_ADDR_W,
   parameter int DATA_W    = MEM_DATA_W,
   parameter int READ_LAT  = 2,
   parameter int WRITE_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cs,
   input  logic              read_req,
   input  logic              write_req,
   input  logic [ADDR_W-1:0] addrout,
   input  logic [DATA_W-1:0] datatomem,
   output logic [DATA_W-1:0] datafrommem,
   output logic              mem_resp,
   output logic              proto_err,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
);

   localparam int LAT_MAX =
      (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
   localparam int LAT_W = $clog2(LAT_MAX + 1);

   mem_state_t        r_state;
   mem_op_t           r_op;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [LAT_W-1:0]  r_lat;
   logic              r_resp;
   logic              r_perr;
   logic [15:0]       r_rd_cnt;
   logic [15:0]       r_wr_cnt;

   logic w_fire;
   logic w_re;
   logic w_we;

   // The access happens on the last ACCESS edge, alongside the RESP move.
   assign w_fire = (r_state == ACCESS) && (r_lat == '0);
   assign w_re   = w_fire && (r_op == MEM_RD);
   assign w_we   = w_fire && (r_op == MEM_WR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_op     <= MEM_RD;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_lat    <= '0;
         r_resp   <= 1'b0;
         r_perr   <= 1'b0;
         r_rd_cnt <= '0;
         r_wr_cnt <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (cs && read_req && write_req) begin
                  r_perr <= 1'b1;
               end else if (cs && read_req) begin
                  r_op    <= MEM_RD;
                  r_addr  <= addrout;
                  r_wdata <= datatomem;
                  r_lat   <= LAT_W'(READ_LAT - 1);
                  r_state <= ACCESS;
               end else if (cs && write_req) begin
                  r_op    <= MEM_WR;
                  r_addr  <= addrout;
                  r_wdata <= datatomem;
                  r_lat   <= LAT_W'(WRITE_LAT - 1);
                  r_state <= ACCESS;
               end
            end
            ACCESS: begin
               if (r_lat == '0) begin
                  r_state <= RESP;
                  r_resp  <= 1'b1;
                  if (r_op == MEM_RD)
                     r_rd_cnt <= r_rd_cnt + 16'd1;
                  else
                     r_wr_cnt <= r_wr_cnt + 16'd1;
               end else begin
                  r_lat <= r_lat - 1'b1;
               end
            end
            RESP: begin
               if (!read_req && !write_req) begin
                  r_state <= IDLE;
                  r_resp  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_resp  <= 1'b0;
            end
         endcase
      end
   end

   mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .i_clk   (clk),
      .i_rst   (reset),
      .i_we    (w_we),
      .i_re    (w_re),
      .i_addr  (r_addr),
      .i_wdata (r_wdata),
      .o_rdata (datafrommem)
   );

   assign mem_resp  = r_resp;
   assign proto_err = r_perr;
   assign rd_count  = r_rd_cnt;
   assign wr_count  = r_wr_cnt;

endmodule
